// File: rtl/led_row_scanner_if.sv
// rtl/led_row_scanner_if.sv - host/display bundle for the LED row scanner
interface led_row_scanner_if;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic [2:0] ROW_SEL;
  logic       ROW_EN;
  logic [7:0] COL;
  logic       swap_ack;
  logic       frame_done;

  modport master (
    output enable, wr_en, wr_row, wr_data, swap_req,
    input  ROW_SEL, ROW_EN, COL, swap_ack, frame_done
  );

  modport slave (
    input  enable, wr_en, wr_row, wr_data, swap_req,
    output ROW_SEL, ROW_EN, COL, swap_ack, frame_done
  );
endinterface

// File: rtl/led_row_scanner.sv
// rtl/led_row_scanner.sv - double-buffered 8x8 LED row-scan controller
module led_row_scanner #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic               clk,
  input  logic               reset,
  led_row_scanner_if.slave   bus
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      row, row_nxt;
  logic            bank_sel;
  logic            pending;
  logic [7:0]      mem [2][8];

  logic            frame_end;
  logic            swap_go;

  logic [2:0]      row_sel_q, row_sel_nxt;
  logic            row_en_q, row_en_nxt;
  logic [7:0]      col_q, col_nxt;
  logic            ack_q, done_q;

  assign bus.ROW_SEL    = row_sel_q;
  assign bus.ROW_EN     = row_en_q;
  assign bus.COL        = col_q;
  assign bus.swap_ack   = ack_q;
  assign bus.frame_done = done_q;

  // Last dwell cycle of row 7 is the only in-frame point where banks may swap;
  // a disabled display swaps immediately so software is never blocked.
  assign frame_end = bus.enable && (state == S_DRIVE) && (cnt == '0) && (row == 3'd7);
  assign swap_go   = (pending || bus.swap_req) && (frame_end || !bus.enable);

  // State, dwell/blank counter and row index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      row   <= row_nxt;
    end
  end

  // Next-state: blank/drive sequencing over rows 0..7, enable low forces idle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    if (!bus.enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      row_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_BLANK;
          cnt_nxt   = BLANK_LD;
          row_nxt   = '0;
        end
        S_BLANK: begin
          if (cnt == '0) begin
            state_nxt = S_DRIVE;
            cnt_nxt   = DWELL_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == '0) begin
            state_nxt = S_BLANK;
            cnt_nxt   = BLANK_LD;
            row_nxt   = row + 3'd1;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state; column data latched on drive entry
  always_comb begin
    row_sel_nxt = (state_nxt == S_IDLE) ? 3'd0 : row_nxt;
    row_en_nxt  = (state_nxt == S_DRIVE);
    col_nxt     = 8'h00;
    if (state_nxt == S_DRIVE) begin
      col_nxt = (state == S_DRIVE) ? col_q : mem[bank_sel][row_nxt];
    end
  end

  // Registered outputs, bank select, swap pending flag and frame buffers
  always_ff @(posedge clk) begin
    if (reset) begin
      row_sel_q <= '0;
      row_en_q  <= 1'b0;
      col_q     <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      bank_sel  <= 1'b0;
      pending   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      row_sel_q <= row_sel_nxt;
      row_en_q  <= row_en_nxt;
      col_q     <= col_nxt;
      ack_q     <= swap_go;
      done_q    <= frame_end;
      pending   <= swap_go ? 1'b0 : (pending || bus.swap_req);
      if (swap_go) begin
        bank_sel <= ~bank_sel;
      end
      // Write targets the pre-swap back bank so it appears in the new front
      if (bus.wr_en) begin
        mem[~bank_sel][bus.wr_row] <= bus.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_led_row_scanner.sv
// tb/tb_led_row_scanner.sv - self-checking bench for led_row_scanner
module tb_led_row_scanner;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int P     = DWELL + BLANK;
  localparam int F     = 8 * P;

  logic clk = 1'b0;
  logic reset;
  led_row_scanner_if bus ();

  led_row_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_ack = 0;
  int n_done = 0;
  int n_en = 0;
  int n_col_nz = 0;

  bit         m_active;
  int         m_phase;
  bit         m_pend;
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];
  logic [2:0] m_sel;
  logic       m_en;
  logic [7:0] m_col;
  logic       m_ack;
  logic       m_done;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-position model: a frame is F cycles, row = phase / P, first BLANK cycles dark
  function automatic void model_edge(bit rst, bit en, bit we, logic [2:0] wr,
                                     logic [7:0] wd, bit sr);
    bit fe, go;
    logic [7:0] t;
    int r, w;
    if (rst) begin
      m_active = 0; m_phase = 0; m_pend = 0;
      for (int i = 0; i < 8; i++) begin m_front[i] = 0; m_back[i] = 0; end
      m_sel = 0; m_en = 0; m_col = 0; m_ack = 0; m_done = 0;
      return;
    end
    fe = m_active && (m_phase == F - 1) && en;
    go = (m_pend || sr) && (fe || !en);
    if (we) m_back[wr] = wd;
    if (go) begin
      for (int i = 0; i < 8; i++) begin
        t = m_front[i]; m_front[i] = m_back[i]; m_back[i] = t;
      end
    end
    m_pend = go ? 1'b0 : (m_pend || sr);
    m_ack  = go;
    m_done = fe;
    if (!en) begin
      m_active = 0; m_phase = 0;
    end else if (!m_active) begin
      m_active = 1; m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % F;
    end
    if (m_active) begin
      r = m_phase / P;
      w = m_phase % P;
      m_sel = 3'(r);
      m_en  = (w >= BLANK);
      m_col = m_en ? m_front[r] : 8'h00;
    end else begin
      m_sel = 0; m_en = 0; m_col = 0;
    end
  endfunction

  task automatic step(input bit rst, input bit en, input bit we, input logic [2:0] wr,
                      input logic [7:0] wd, input bit sr);
    reset        = rst;
    bus.enable   = en;
    bus.wr_en    = we;
    bus.wr_row   = wr;
    bus.wr_data  = wd;
    bus.swap_req = sr;
    @(posedge clk);
    model_edge(rst, en, we, wr, wd, sr);
    #1;
    chk("row_sel", 8'(bus.ROW_SEL), 8'(m_sel));
    chk("row_en", 8'(bus.ROW_EN), 8'(m_en));
    chk("col", bus.COL, m_col);
    chk("swap_ack", 8'(bus.swap_ack), 8'(m_ack));
    chk("frame_done", 8'(bus.frame_done), 8'(m_done));
    if (bus.swap_ack === 1'b1) n_ack++;
    if (bus.frame_done === 1'b1) n_done++;
    if (bus.ROW_EN === 1'b1) n_en++;
    if (bus.COL !== 8'h00) n_col_nz++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 3'd0, 8'h00, 0);
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < F + 2; i++) begin
      if (m_active && m_phase == ph) return;
      step(0, 1, 0, 3'd0, 8'h00, 0);
    end
    chk("run_to_phase_timeout", 8'd1, 8'd0);
  endtask

  initial begin
    m_active = 0; m_phase = 0; m_pend = 0;
    reset = 1; bus.enable = 0; bus.wr_en = 0; bus.wr_row = 0; bus.wr_data = 0; bus.swap_req = 0;

    // Reset state
    step(1, 0, 0, 3'd0, 8'h00, 0);
    step(1, 1, 0, 3'd0, 8'h00, 0);
    chk("reset_row_en", 8'(bus.ROW_EN), 8'd0);
    chk("reset_col", bus.COL, 8'h00);

    // Free-running scan: period and duty
    run(10);
    n_done = 0; n_en = 0;
    run(2 * F);
    chk("frame_done_per_96", 8'(n_done), 8'd2);
    chk("row_en_per_96", 8'(n_en), 8'(2 * 8 * DWELL));

    // Back[3]=A5, swap requested during row 2
    run_to_phase(2 * P + 1);
    step(0, 1, 1, 3'd3, 8'hA5, 0);
    n_ack = 0;
    step(0, 1, 0, 3'd0, 8'h00, 1);
    run(2 * F);
    chk("single_swap_a5", 8'(n_ack), 8'd1);

    // Two requests in one frame produce a single swap
    run_to_phase(5);
    n_ack = 0;
    step(0, 1, 0, 3'd0, 8'h00, 1);
    run_to_phase(20);
    step(0, 1, 0, 3'd0, 8'h00, 1);
    run(40);
    chk("double_req_one_ack", 8'(n_ack), 8'd1);
    run(F);

    // Drop enable during row 5 drive
    run_to_phase(5 * P + BLANK + 1);
    step(0, 0, 0, 3'd0, 8'h00, 0);
    chk("drop_row_en", 8'(bus.ROW_EN), 8'd0);
    chk("drop_col", bus.COL, 8'h00);
    chk("drop_row_sel", 8'(bus.ROW_SEL), 8'd0);
    step(0, 1, 0, 3'd0, 8'h00, 0);
    chk("reen_blank0", 8'(bus.ROW_EN), 8'd0);
    step(0, 1, 0, 3'd0, 8'h00, 0);
    chk("reen_blank1", 8'(bus.ROW_EN), 8'd0);
    step(0, 1, 0, 3'd0, 8'h00, 0);
    chk("reen_drive", 8'(bus.ROW_EN), 8'd1);

    // Reset during drive with a swap pending
    run_to_phase(BLANK);
    step(0, 1, 0, 3'd0, 8'h00, 1);
    step(0, 1, 0, 3'd0, 8'h00, 0);
    step(1, 1, 0, 3'd0, 8'h00, 0);
    chk("rst_mid_ack", 8'(bus.swap_ack), 8'd0);
    chk("rst_mid_row_en", 8'(bus.ROW_EN), 8'd0);
    n_col_nz = 0;
    n_ack = 0;
    run(2 * F);
    chk("rst_all_rows_zero", 8'(n_col_nz), 8'd0);
    chk("rst_no_ack", 8'(n_ack), 8'd0);

    // Swap while dark
    step(0, 0, 0, 3'd0, 8'h00, 0);
    step(0, 0, 1, 3'd0, 8'hFF, 0);
    step(0, 0, 0, 3'd0, 8'h00, 1);
    chk("idle_swap_ack", 8'(bus.swap_ack), 8'd1);
    for (int i = 0; i < P; i++) begin
      step(0, 1, 0, 3'd0, 8'h00, 0);
      if (i == BLANK) chk("idle_swap_col_ff", bus.COL, 8'hFF);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 700) == 0, ($urandom % 80) != 0, ($urandom % 4) == 0,
           3'($urandom), 8'($urandom), ($urandom % 50) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_row_scanner.md
Name: led_row_scanner

Overview:
- Row-scan controller for the 8x8 LED array; sits directly upstream of the 3:8 active-low row decoder.
- Holds a double-buffered 8x8 frame: game logic writes the back bank, the scanner displays the front bank.
- Drives a 3-bit row index into the decoder plus 8 column bits for the current row.
- Inserts blanking between rows to prevent ghosting, and swaps banks only at frame boundaries.

Parameters:
- DWELL, 1000: cycles each row is driven (ROW_EN=1); legal range >= 1.
- BLANK, 16: blanking cycles before each row (ROW_EN=0, COL=0); legal range >= 1.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  scan enable; 0 holds the display dark
- wr_en  input  1  write strobe into the back bank
- wr_row  input  3  back-bank row address
- wr_data  input  8  back-bank row data; bit i = column i
- swap_req  input  1  one-cycle request to exchange the front and back banks
- ROW_SEL  output  3  row index; connects to the decoder IN
- ROW_EN  output  1  1 = row driven; external gating of the decoder outputs
- COL  output  8  column drive for ROW_SEL, from the front bank
- swap_ack  output  1  one-cycle pulse in the cycle the swap takes effect
- frame_done  output  1  one-cycle pulse at the end of row 7 DRIVE

Behaviour:
- Reset: state=IDLE, ROW_SEL=0, ROW_EN=0, COL=0, swap_ack=0, frame_done=0, bank select=0, swap pending=0, counter=0. Both banks are cleared to 0.
- All outputs are registered. Reset has priority over every other input.
- Counter width is clog2(max(DWELL,BLANK)+1).
- Reset mid-operation: the next cycle is reset state, regardless of the current state.
- States:
  - IDLE: ROW_EN=0, COL=0, ROW_SEL=0.
  - BLANK: ROW_EN=0, COL=0, ROW_SEL = current row.
  - DRIVE: ROW_EN=1, COL = front[row].
- Transitions:
  - IDLE -> BLANK when enable=1; row=0, counter loaded.
  - BLANK: stays exactly BLANK cycles, then -> DRIVE.
  - On entry to DRIVE, COL is loaded from front[row] and held constant for the whole dwell.
  - DRIVE: stays exactly DWELL cycles.
  - On the last DRIVE cycle, frame_done pulses if row=7. The next state is BLANK with row+1; row wraps from 7 to 0.
  - enable=0 in any state -> IDLE next cycle, outputs dark, row reset to 0. Re-enabling restarts at row 0 with BLANK.
- Row period = BLANK+DWELL cycles. Frame period = 8*(BLANK+DWELL) cycles.
- ROW_SEL changes only on the BLANK entry edge, never while ROW_EN=1.
- Writes:
  - When wr_en=1, back[wr_row] <= wr_data next cycle.
  - Writes are accepted in every state, including IDLE.
  - Writes never alter the front bank.
- Swap:
  - swap_req sets pending. Further requests while pending are absorbed: a single swap occurs.
  - When pending is set (or swap_req=1 in the same cycle) on the last DRIVE cycle of row 7, the bank select toggles on that edge, swap_ack pulses in the same cycle as frame_done, and pending clears.
  - Row 0 of the next frame shows the new front.
  - The new back bank holds the old front contents; no copy is made.
- Swap while idle: if pending is set and enable=0, the swap executes on the next cycle (swap_ack pulses), so a dark display never blocks software.
- Write and swap on the same edge: the write lands in the pre-swap back bank, so its data becomes visible in the new front.

Test Plan:
- DWELL=4, BLANK=2, reset then enable=1:
  - ROW_SEL steps 0..7 with a 6-cycle period.
  - ROW_EN is high for exactly 4 of every 6 cycles.
  - frame_done pulses every 48 cycles.
  - ROW_SEL wraps 7 -> 0.
- Write back[3]=0xA5, swap_req mid-frame (row 2):
  - No change until the row 7 end; swap_ack coincides with frame_done.
  - On the next frame, COL=0xA5 exactly while ROW_SEL=3 and ROW_EN=1. Other rows show 0x00.
- Two swap_req pulses within one frame:
  - Exactly one swap_ack.
  - The display bank toggles once; the second frame shows the original bank.
- Drop enable while in DRIVE on row 5:
  - Next cycle ROW_EN=0, COL=0, ROW_SEL=0.
  - On re-enable, a 2-cycle BLANK on row 0 precedes DRIVE.
- Assert reset during DRIVE with a swap pending:
  - Next cycle all outputs are 0 and no swap_ack occurs.
  - All rows read 0x00 after re-enable.
- enable=0, write back[0]=0xFF, then swap_req:
  - swap_ack fires the next cycle.
  - After enable=1, COL=0xFF in the row 0 drive window.
